apb_dual_mst_arbiter: RTL and testbench

- Two-port APB master front-end that shares one APB slave between two simple request/acknowledge requesters. The slave is typically the dual-port APB memory.
- Arbitrates round-robin and sequences the APB IDLE/SETUP/ACCESS protocol.
- Returns read data and the error status to the winning requester.
- Has a programmable PREADY timeout, so a hung slave cannot stall either requester.

---
 rtl/apb_dual_mst_arbiter_if.sv | 26 ++
 rtl/apb_dual_mst_arbiter.sv | 163 ++++++++++++++++
 tb/tb_apb_dual_mst_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_dual_mst_arbiter_if.sv
// APB bus bundle between the dual-requester arbiter (master side) and the shared slave.
interface apb_dual_mst_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_WIDTH-1:0] PSTRB;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_dual_mst_arbiter.sv
// Round-robin APB master front-end sharing one APB slave between two
// request/acknowledge requesters, with a programmable PREADY timeout.
module apb_dual_mst_arbiter #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic [1:0]                 req_i,
    input  logic [1:0]                 we_i,
    input  logic [1:0][ADDR_WIDTH-1:0] addr_i,
    input  logic [1:0][DATA_WIDTH-1:0] wdata_i,
    input  logic [1:0][STRB_WIDTH-1:0] strb_i,
    output logic [1:0]                 ack_o,
    output logic [1:0][DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]                 err_o,
    apb_dual_mst_arbiter_if.master     apb
);
    localparam int unsigned TMR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic                       ptr_q, ptr_d;
    logic                       gnt_q, gnt_d;
    logic                       psel_q, psel_d;
    logic                       penable_q, penable_d;
    logic                       pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]      paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]      pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]      pstrb_q, pstrb_d;
    logic [1:0]                 ack_q, ack_d;
    logic [1:0]                 err_q, err_d;
    logic [1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [TMR_W-1:0]           tmr_q, tmr_d;

    logic [1:0]                 elig;
    logic                       sel;
    logic [TMR_W-1:0]           tmr_inc;
    logic                       tmo_hit;

    // Next-state, grant selection and APB/requester output updates
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        ack_d     = 2'b00;
        err_d     = err_q;
        rdata_d   = rdata_q;
        tmr_d     = tmr_q;
        // A requester's req is still high during its own ack cycle; mask it there.
        elig      = req_i & ~ack_q;
        sel       = 1'b0;
        tmr_inc   = tmr_q + TMR_W'(1);
        tmo_hit   = (TIMEOUT != 32'd0) && (tmr_inc == TMR_W'(TIMEOUT));

        unique case (state_q)
            ST_IDLE: begin
                if (elig != 2'b00) begin
                    if (elig == 2'b11) begin
                        sel   = ptr_q;
                        ptr_d = ~ptr_q;
                    end else begin
                        sel = elig[1];
                    end
                    gnt_d     = sel;
                    pwrite_d  = we_i[sel];
                    paddr_d   = addr_i[sel];
                    pwdata_d  = wdata_i[sel];
                    pstrb_d   = we_i[sel] ? strb_i[sel] : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    tmr_d     = '0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (apb.PREADY) begin
                    ack_d[gnt_q]   = 1'b1;
                    err_d[gnt_q]   = apb.PSLVERR;
                    rdata_d[gnt_q] = pwrite_q ? '0 : apb.PRDATA;
                    psel_d         = 1'b0;
                    penable_d      = 1'b0;
                    state_d        = ST_IDLE;
                end else begin
                    tmr_d = tmr_inc;
                    if (tmo_hit) begin
                        ack_d[gnt_q]   = 1'b1;
                        err_d[gnt_q]   = 1'b1;
                        rdata_d[gnt_q] = '0;
                        psel_d         = 1'b0;
                        penable_d      = 1'b0;
                        state_d        = ST_IDLE;
                    end
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 1'b0;
            gnt_q     <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            ack_q     <= 2'b00;
            err_q     <= 2'b00;
            rdata_q   <= '0;
            tmr_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            tmr_q     <= tmr_d;
        end
    end

    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;
    assign apb.PSTRB   = pstrb_q;

    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
endmodule

// File: tb/tb_apb_dual_mst_arbiter.sv
// Self-checking bench: two requester drivers, a memory-backed APB slave with
// address-selected wait/error/hang behaviour, and a transaction-level reference.
module tb_apb_dual_mst_arbiter;
    localparam int unsigned AW  = 10;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned TMO = 16;

    logic                PCLK = 1'b0;
    logic                PRESETn;
    logic [1:0]          req, we;
    logic [1:0][AW-1:0]  addr;
    logic [1:0][DW-1:0]  wdata;
    logic [1:0][SW-1:0]  strb;
    logic [1:0]          ack_o, err_o;
    logic [1:0][DW-1:0]  rdata_o;

    int n_chk = 0;
    int n_bad = 0;

    apb_dual_mst_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) apb ();

    apb_dual_mst_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT(TMO)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .strb_i(strb),
        .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o),
        .apb(apb)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Slave behaviour: 0x3D0-0x3DF answer with PSLVERR, 0x3E0-0x3EF never answer,
    // everything else waits addr[1:0] cycles unless wait_ovr overrides it.
    int       wait_ovr;
    bit       force_err;
    bit [DW-1:0] smem [1024];
    bit [DW-1:0] ref_mem [1024];

    function automatic bit is_hang(input logic [AW-1:0] a);
        return a[9:4] == 6'h3E;
    endfunction

    function automatic bit is_err(input logic [AW-1:0] a);
        return a[9:4] == 6'h3D;
    endfunction

    function automatic int slv_wait(input logic [AW-1:0] a);
        if (wait_ovr >= 0) return wait_ovr;
        return int'(a[1:0]);
    endfunction

    int acc_cnt = 0;
    int wait_need;
    logic slv_ready;

    assign wait_need     = (apb.PADDR[9:4] == 6'h3E) ? 100000
                         : ((wait_ovr >= 0) ? wait_ovr : int'(apb.PADDR[1:0]));
    assign slv_ready     = apb.PSEL && apb.PENABLE && (acc_cnt >= wait_need);
    assign apb.PREADY    = slv_ready;
    assign apb.PRDATA    = smem[apb.PADDR];
    assign apb.PSLVERR   = slv_ready && (force_err || apb.PADDR[9:4] == 6'h3D);

    always @(posedge PCLK) begin
        if (apb.PSEL && apb.PENABLE && !slv_ready) acc_cnt <= acc_cnt + 1;
        else                                       acc_cnt <= 0;
        if (slv_ready && apb.PWRITE && !apb.PSLVERR)
            for (int b = 0; b < int'(SW); b++)
                if (apb.PSTRB[b]) smem[apb.PADDR][8*b +: 8] <= apb.PWDATA[8*b +: 8];
    end

    // Bus monitor: protocol shape, per-transfer ACCESS length, ack exclusivity and turn-taking
    bit          prev_psel = 1'b0;
    bit          setup_seen = 1'b0;
    int          mon_acc = 0;
    logic [AW-1:0] mon_addr = '0;
    bit          mon_we = 1'b0;
    int          n_setup = 0;
    int          n_ack [2] = '{0, 0};
    int          owed = -1;
    int          ack_log [$];

    initial begin
        int ai;
        forever begin
            @(negedge PCLK);
            if (!PRESETn) begin
                prev_psel  = 1'b0;
                setup_seen = 1'b0;
                owed       = -1;
            end else begin
                if (setup_seen) chk("setup_to_access", {apb.PSEL, apb.PENABLE}, 2'b11);
                setup_seen = 1'b0;
                if (apb.PSEL && !apb.PENABLE) begin
                    chk("gap_before_setup", prev_psel, 0);
                    if (!apb.PWRITE) chk("pstrb_on_read", apb.PSTRB, 0);
                    n_setup++;
                    mon_acc    = 0;
                    mon_addr   = apb.PADDR;
                    mon_we     = apb.PWRITE;
                    setup_seen = 1'b1;
                end else if (apb.PSEL && apb.PENABLE) begin
                    mon_acc++;
                    chk("paddr_stable", apb.PADDR, mon_addr);
                end
                if (ack_o != 2'b00) begin
                    ai = ack_o[1] ? 1 : 0;
                    chk("one_ack", $countones(ack_o), 1);
                    chk("ack_outside_xfer", apb.PSEL, 0);
                    if (owed >= 0) chk("rr_turn", ai, owed);
                    // A requester already waiting when the other is acked must be served next.
                    owed = (req[1-ai] && !ack_o[1-ai]) ? 1 - ai : -1;
                    n_ack[ai]++;
                    ack_log.push_back(ai);
                end
                prev_psel = apb.PSEL;
            end
        end
    end

    // One requester transaction; called at posedge+1, returns at posedge+1 after the ack cycle
    task automatic do_req(input int i, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s, output int lat);
        bit            got;
        bit            exp_err;
        logic [DW-1:0] exp_rd;
        int            exp_acc;
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d; strb[i] = s;
        got = 1'b0;
        lat = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge PCLK);
            lat++;
            got = ack_o[i];
        end
        lat = lat - 1;
        if (!got) begin
            chk($sformatf("ack_wait%0d", i), 0, 1);
            return;
        end
        exp_err = force_err || is_err(a) || is_hang(a);
        exp_rd  = (w || is_hang(a)) ? '0 : ref_mem[a];
        exp_acc = is_hang(a) ? int'(TMO) : slv_wait(a) + 1;
        chk($sformatf("err%0d", i), err_o[i], exp_err);
        chk($sformatf("rdata%0d", i), rdata_o[i], exp_rd);
        chk($sformatf("access_cycles%0d", i), mon_acc, exp_acc);
        chk($sformatf("paddr%0d", i), mon_addr, a);
        chk($sformatf("pwrite%0d", i), mon_we, w);
        if (w && !exp_err)
            for (int b = 0; b < int'(SW); b++)
                if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        @(posedge PCLK);
        #1;
        chk($sformatf("ack_pulse%0d", i), ack_o[i], 0);
        chk($sformatf("rdata_hold%0d", i), rdata_o[i], exp_rd);
    endtask

    task automatic drop(input int i);
        req[i] = 1'b0;
    endtask

    task automatic rand_requester(input int i, input int n);
        int            gap, r, lat;
        logic [AW-1:0] a;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                drop(i);
                repeat (gap) @(posedge PCLK);
                #1;
            end
            r = $urandom_range(0, 99);
            if (r < 6)       a = 10'h3E0 | 10'($urandom_range(0, 15));
            else if (r < 16) a = 10'h3D0 | 10'($urandom_range(0, 15));
            else             a = 10'($urandom_range(0, 15));
            do_req(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), lat);
        end
        drop(i);
    endtask

    initial begin
        int lat, lat0, lat1, na0, na1, s0;
        PRESETn   = 1'b0;
        req       = '0; we = '0; addr = '0; wdata = '0; strb = '0;
        wait_ovr  = -1;
        force_err = 1'b0;

        repeat (2) @(negedge PCLK);
        chk("rst_psel", apb.PSEL, 0);
        chk("rst_penable", apb.PENABLE, 0);
        chk("rst_pwrite", apb.PWRITE, 0);
        chk("rst_paddr", apb.PADDR, 0);
        chk("rst_pwdata", apb.PWDATA, 0);
        chk("rst_pstrb", apb.PSTRB, 0);
        chk("rst_ack", ack_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rdata", rdata_o, 0);
        PRESETn = 1'b1;
        @(posedge PCLK);
        #1;

        // Both requesters reading back-to-back from reset: strict alternation starting at 0
        ack_log.delete();
        fork
            begin
                for (int k = 0; k < 4; k++) do_req(0, 1'b0, 10'h030, '0, '0, lat0);
                drop(0);
            end
            begin
                for (int k = 0; k < 4; k++) do_req(1, 1'b0, 10'h040, '0, '0, lat1);
                drop(1);
            end
        join
        chk("rr_count", ack_log.size(), 8);
        for (int k = 0; k < ack_log.size(); k++) chk($sformatf("rr_order%0d", k), ack_log[k], k % 2);
        repeat (2) @(posedge PCLK);
        #1;

        // Write with four wait states, then read back by the other requester
        wait_ovr = 4;
        do_req(0, 1'b1, 10'h020, 32'hDEADBEEF, 4'hF, lat);
        chk("wr_latency", lat, 7);
        chk("wr_err", err_o[0], 0);
        drop(0);
        wait_ovr = -1;
        do_req(1, 1'b0, 10'h020, '0, '0, lat);
        chk("rd_latency", lat, 3);
        chk("rd_back", rdata_o[1], 32'hDEADBEEF);
        drop(1);

        // Slave error on the first ACCESS cycle
        wait_ovr  = 0;
        force_err = 1'b1;
        do_req(1, 1'b1, 10'h005, 32'h12345678, 4'hF, lat);
        chk("slverr_latency", lat, 3);
        chk("slverr_err", err_o[1], 1);
        chk("slverr_rdata", rdata_o[1], 0);
        drop(1);
        force_err = 1'b0;
        wait_ovr  = -1;
        repeat (2) @(negedge PCLK);
        chk("slverr_idle", apb.PSEL, 0);
        @(posedge PCLK);
        #1;

        // Hung slave: abort after TIMEOUT ACCESS cycles, then a normal transfer
        do_req(0, 1'b0, 10'h3E4, '0, '0, lat);
        chk("tmo_latency", lat, 2 + int'(TMO));
        chk("tmo_err", err_o[0], 1);
        chk("tmo_rdata", rdata_o[0], 0);
        drop(0);
        do_req(0, 1'b0, 10'h020, '0, '0, lat);
        chk("post_tmo_latency", lat, 3);
        chk("post_tmo_rdata", rdata_o[0], 32'hDEADBEEF);
        drop(0);

        // req held through its own ack cycle must not start a second transfer
        s0 = n_setup;
        do_req(0, 1'b0, 10'h008, '0, '0, lat);
        drop(0);
        repeat (6) @(negedge PCLK);
        chk("no_dup_transfer", n_setup, s0 + 1);
        @(posedge PCLK);
        #1;

        // Reset during ACCESS aborts without ack; pending requester 1 is served afterwards
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 10'h3E0; wdata[0] = '0; strb[0] = '0;
        for (int c = 0; c < 10 && !(apb.PSEL && apb.PENABLE); c++) @(negedge PCLK);
        chk("rst_in_access", {apb.PSEL, apb.PENABLE}, 2'b11);
        chk("rst_gnt_addr", apb.PADDR, 10'h3E0);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 10'h044; wdata[1] = '0; strb[1] = '0;
        na0 = n_ack[0];
        na1 = n_ack[1];
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        chk("rst_abort_psel", apb.PSEL, 0);
        chk("rst_abort_penable", apb.PENABLE, 0);
        chk("rst_abort_ack", ack_o, 0);
        @(posedge PCLK);
        #1;
        drop(0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        do_req(1, 1'b0, 10'h044, '0, '0, lat);
        chk("rst_no_ack0", n_ack[0], na0);
        chk("rst_ack1_once", n_ack[1], na1 + 1);
        drop(1);
        repeat (2) @(posedge PCLK);
        #1;

        // Randomized concurrent traffic checked against the reference memory
        fork
            rand_requester(0, 30);
            rand_requester(1, 30);
        join
        repeat (4) @(posedge PCLK);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
